// File: rtl/sphere_sched_pkg.sv
// Shared types for the sphere/ray scheduler: FSM states, table entries,
// captured rays and the per-sphere result record.
package sphere_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    EMIT,
    DONE
  } sched_state_t;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
    logic signed [15:0] radius;
  } sphere_t;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
  } vec3_t;

  typedef struct packed {
    vec3_t start;
    vec3_t dir;
  } ray_t;

  // Index is sized for the largest table; the scheduler narrows it on output.
  localparam int MaxIdxW = 16;

  typedef struct packed {
    logic [MaxIdxW-1:0] index;
    logic               intersects;
    logic [15:0]        discriminant;
    logic [15:0]        b;
  } result_t;

endpackage

// File: rtl/sphere_table.sv
// Sphere register file: one 64-bit {X,Y,Z,Radius} entry per sphere,
// asynchronous read, gated write, cleared by reset.
module sphere_table
  import sphere_sched_pkg::*;
#(
  parameter int NumSpheres = 8,
  parameter int IdxW       = 3
) (
  input  logic            CLK,
  input  logic            aresetn,
  input  logic            writeEnable,
  input  logic [IdxW-1:0] writeAddr,
  input  logic [63:0]     writeData,
  input  logic [IdxW-1:0] readAddr,
  output logic [63:0]     readData
);

  sphere_t mem [NumSpheres];

  // NOTE: the table is architecturally visible after reset, so it sits in the
  // reset domain; state registers use <= so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NumSpheres; i++) mem[i] <= '0;
    end else if (writeEnable) begin
      // Decoding against real entries drops addresses past the table end.
      for (int i = 0; i < NumSpheres; i++) begin
        if (writeAddr == IdxW'(i)) mem[i] <= writeData;
      end
    end
  end

  assign readData = mem[readAddr];

endmodule

// File: rtl/sphere_ray_scheduler.sv
// Runs one ray against the sphere table through a single external
// discriminant calculator, one sphere in flight, results streamed out.
module sphere_ray_scheduler
  import sphere_sched_pkg::*;
#(
  parameter int NumSpheres = 8,
  parameter int IdxW       = (NumSpheres > 1) ? $clog2(NumSpheres) : 1,
  parameter int CntW       = $clog2(NumSpheres + 1)
) (
  input  logic                  CLK,
  input  logic                  aresetn,
  input  logic                  SphereWrite,
  input  logic [IdxW-1:0]       SphereWrAddr,
  input  logic [63:0]           SphereWrData,
  input  logic [CntW-1:0]       SphereCount,
  input  logic                  RayValid,
  output logic                  RayReady,
  input  logic [47:0]           RayStart,
  input  logic [47:0]           RayDir,
  output logic [15:0]           CalcSphereX,
  output logic [15:0]           CalcSphereY,
  output logic [15:0]           CalcSphereZ,
  output logic [15:0]           CalcSphereRadius,
  output logic [15:0]           CalcRayStartX,
  output logic [15:0]           CalcRayStartY,
  output logic [15:0]           CalcRayStartZ,
  output logic [15:0]           CalcRayDirX,
  output logic [15:0]           CalcRayDirY,
  output logic [15:0]           CalcRayDirZ,
  output logic                  CalcInputValid,
  input  logic                  CalcInputReady,
  input  logic                  CalcOutputReady,
  input  logic                  CalcQuickIntersects,
  input  logic [15:0]           CalcDiscriminant,
  input  logic [15:0]           CalcB,
  output logic                  ResultValid,
  input  logic                  ResultReady,
  output logic [IdxW-1:0]       ResultIndex,
  output logic                  ResultIntersects,
  output logic [15:0]           ResultDiscriminant,
  output logic [15:0]           ResultB,
  output logic                  ResultLast,
  output logic                  RayDone,
  output logic [NumSpheres-1:0] HitMask,
  output logic [CntW-1:0]       HitCount
);

  sched_state_t    state, stateNext;
  logic [IdxW-1:0] idx;
  logic [CntW-1:0] rayCount;
  logic [CntW-1:0] countClamped;
  logic            outOfReset;
  logic            isLast;
  ray_t            rayReg;
  result_t         resultReg;
  sphere_t         sphere;

  sphere_table #(
    .NumSpheres(NumSpheres),
    .IdxW      (IdxW)
  ) sphereTable (
    .CLK        (CLK),
    .aresetn    (aresetn),
    .writeEnable(SphereWrite && (state == IDLE)),
    .writeAddr  (SphereWrAddr),
    .writeData  (SphereWrData),
    .readAddr   (idx),
    .readData   (sphere)
  );

  assign countClamped = (SphereCount > CntW'(NumSpheres)) ? CntW'(NumSpheres) : SphereCount;
  assign isLast       = (CntW'(idx) == rayCount - 1'b1);

  // Held low through reset and until the first edge after release.
  assign RayReady = (state == IDLE) && outOfReset;

  always_ff @(posedge CLK or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      outOfReset <= 1'b0;
    end else begin
      state      <= stateNext;
      outOfReset <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves stateNext unassigned.
    stateNext = state;
    unique case (state)
      IDLE:  if (RayValid && RayReady) stateNext = (countClamped == '0) ? DONE : ISSUE;
      ISSUE: if (CalcInputReady) stateNext = WAIT;
      WAIT:  if (CalcOutputReady) stateNext = EMIT;
      EMIT:  if (ResultReady) stateNext = isLast ? DONE : ISSUE;
      DONE:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge aresetn) begin
    if (!aresetn) begin
      idx       <= '0;
      rayCount  <= '0;
      rayReg    <= '0;
      resultReg <= '0;
      HitMask   <= '0;
      HitCount  <= '0;
    end else begin
      unique case (state)
        IDLE: if (RayValid && RayReady) begin
          rayReg   <= '{start: RayStart, dir: RayDir};
          rayCount <= countClamped;
          idx      <= '0;
          HitMask  <= '0;
          HitCount <= '0;
        end
        // Leaving WAIT on the capture cycle means a lingering OutputReady is ignored.
        WAIT: if (CalcOutputReady) begin
          resultReg <= '{index:        MaxIdxW'(idx),
                         intersects:   CalcQuickIntersects,
                         discriminant: CalcDiscriminant,
                         b:            CalcB};
          if (CalcQuickIntersects) begin
            HitMask[idx] <= 1'b1;
            HitCount     <= HitCount + 1'b1;
          end
        end
        EMIT: if (ResultReady && !isLast) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  assign CalcInputValid   = (state == ISSUE);
  assign CalcSphereX      = sphere.x;
  assign CalcSphereY      = sphere.y;
  assign CalcSphereZ      = sphere.z;
  assign CalcSphereRadius = sphere.radius;
  assign CalcRayStartX    = rayReg.start.x;
  assign CalcRayStartY    = rayReg.start.y;
  assign CalcRayStartZ    = rayReg.start.z;
  assign CalcRayDirX      = rayReg.dir.x;
  assign CalcRayDirY      = rayReg.dir.y;
  assign CalcRayDirZ      = rayReg.dir.z;

  assign ResultValid        = (state == EMIT);
  assign ResultIndex        = IdxW'(resultReg.index);
  assign ResultIntersects   = resultReg.intersects;
  assign ResultDiscriminant = resultReg.discriminant;
  assign ResultB            = resultReg.b;
  assign ResultLast         = (state == EMIT) && isLast;
  assign RayDone            = (state == DONE);

endmodule

// File: tb/tb_sphere_ray_scheduler.sv
// Scoreboard bench: a calculator stub answers issues, a reference model
// predicts every result and ray summary, a monitor compares DUT output.
module tb_sphere_ray_scheduler;

  localparam int NumSpheres = 8;
  localparam int IdxW       = 3;
  localparam int CntW       = 4;

  logic CLK = 1'b0;
  logic aresetn = 1'b0;
  logic SphereWrite;
  logic [IdxW-1:0] SphereWrAddr;
  logic [63:0] SphereWrData;
  logic [CntW-1:0] SphereCount;
  logic RayValid, RayReady;
  logic [47:0] RayStart, RayDir;
  logic [15:0] CalcSphereX, CalcSphereY, CalcSphereZ, CalcSphereRadius;
  logic [15:0] CalcRayStartX, CalcRayStartY, CalcRayStartZ;
  logic [15:0] CalcRayDirX, CalcRayDirY, CalcRayDirZ;
  logic CalcInputValid, CalcInputReady, CalcOutputReady, CalcQuickIntersects;
  logic [15:0] CalcDiscriminant, CalcB;
  logic ResultValid, ResultReady, ResultIntersects, ResultLast, RayDone;
  logic [IdxW-1:0] ResultIndex;
  logic [15:0] ResultDiscriminant, ResultB;
  logic [NumSpheres-1:0] HitMask;
  logic [CntW-1:0] HitCount;

  sphere_ray_scheduler #(.NumSpheres(NumSpheres)) dut (
    .CLK(CLK), .aresetn(aresetn),
    .SphereWrite(SphereWrite), .SphereWrAddr(SphereWrAddr), .SphereWrData(SphereWrData),
    .SphereCount(SphereCount), .RayValid(RayValid), .RayReady(RayReady),
    .RayStart(RayStart), .RayDir(RayDir),
    .CalcSphereX(CalcSphereX), .CalcSphereY(CalcSphereY), .CalcSphereZ(CalcSphereZ),
    .CalcSphereRadius(CalcSphereRadius),
    .CalcRayStartX(CalcRayStartX), .CalcRayStartY(CalcRayStartY), .CalcRayStartZ(CalcRayStartZ),
    .CalcRayDirX(CalcRayDirX), .CalcRayDirY(CalcRayDirY), .CalcRayDirZ(CalcRayDirZ),
    .CalcInputValid(CalcInputValid), .CalcInputReady(CalcInputReady),
    .CalcOutputReady(CalcOutputReady), .CalcQuickIntersects(CalcQuickIntersects),
    .CalcDiscriminant(CalcDiscriminant), .CalcB(CalcB),
    .ResultValid(ResultValid), .ResultReady(ResultReady), .ResultIndex(ResultIndex),
    .ResultIntersects(ResultIntersects), .ResultDiscriminant(ResultDiscriminant),
    .ResultB(ResultB), .ResultLast(ResultLast), .RayDone(RayDone),
    .HitMask(HitMask), .HitCount(HitCount)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0]  idx;
    logic        hit;
    logic [15:0] disc;
    logic [15:0] b;
    logic        last;
  } exp_res_t;

  typedef struct packed {
    logic [63:0] sphere;
    logic [47:0] start;
    logic [47:0] dir;
  } exp_issue_t;

  typedef struct packed {
    logic [7:0] mask;
    logic [7:0] count;
  } exp_sum_t;

  exp_res_t   expRes[$];
  exp_issue_t expIssue[$];
  exp_sum_t   expSum[$];
  logic [63:0] shadow [NumSpheres];

  int checks = 0, errors = 0;
  int doneCount = 0, raysSent = 0, issuedCount = 0;
  int readyMode = 2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ray-sphere quadratic with plain integers: returns {hit, disc[15:0], b[15:0]}.
  function automatic logic [32:0] calcModel(input logic [63:0] s, input logic [47:0] st,
                                            input logic [47:0] d);
    longint ox, oy, oz, dx, dy, dz, r, a, b, c, disc;
    ox = longint'($signed(st[47:32])) - longint'($signed(s[63:48]));
    oy = longint'($signed(st[31:16])) - longint'($signed(s[47:32]));
    oz = longint'($signed(st[15:0]))  - longint'($signed(s[31:16]));
    r  = longint'($signed(s[15:0]));
    dx = longint'($signed(d[47:32]));
    dy = longint'($signed(d[31:16]));
    dz = longint'($signed(d[15:0]));
    a = dx * dx + dy * dy + dz * dz;
    b = 2 * (dx * ox + dy * oy + dz * oz);
    c = ox * ox + oy * oy + oz * oz - r * r;
    disc = b * b - 4 * a * c;
    return {disc >= 0, disc[15:0], b[15:0]};
  endfunction

  function automatic logic [15:0] r16();
    int v;
    v = int'($urandom_range(0, 40)) - 20;
    return 16'(v);
  endfunction

  function automatic logic [47:0] randVec();
    return {r16(), r16(), r16()};
  endfunction

  function automatic logic [63:0] randSphere();
    return {r16(), r16(), r16(), 16'($urandom_range(0, 20))};
  endfunction

  // Calculator stub: random input readiness, latency and output hold time.
  initial begin
    int lat, hold;
    bit xfer;
    logic [32:0] m;
    logic [63:0] sph;
    logic [47:0] st, dr;
    exp_issue_t e;
    lat = 0; hold = 0;
    CalcInputReady = 0; CalcOutputReady = 0;
    CalcQuickIntersects = 0; CalcDiscriminant = 0; CalcB = 0;
    forever begin
      @(negedge CLK);
      xfer = aresetn && CalcInputValid && CalcInputReady;
      if (xfer) begin
        sph = {CalcSphereX, CalcSphereY, CalcSphereZ, CalcSphereRadius};
        st  = {CalcRayStartX, CalcRayStartY, CalcRayStartZ};
        dr  = {CalcRayDirX, CalcRayDirY, CalcRayDirZ};
        if (expIssue.size() == 0) check("unexpected_issue", 1, 0);
        else begin
          e = expIssue.pop_front();
          check("issue_sphere", sph, e.sphere);
          check("issue_ray_start", 64'(st), 64'(e.start));
          check("issue_ray_dir", 64'(dr), 64'(e.dir));
        end
      end
      @(posedge CLK); #1;
      if (!aresetn) begin
        lat = 0; hold = 0;
        CalcInputReady = 0; CalcOutputReady = 0;
      end else begin
        if (xfer) begin
          m = calcModel(sph, st, dr);
          lat = int'($urandom_range(1, 4));
          CalcOutputReady = 0;
          issuedCount++;
        end else if (lat > 0) begin
          lat--;
          if (lat == 0) begin
            CalcOutputReady = 1;
            {CalcQuickIntersects, CalcDiscriminant, CalcB} = m;
            hold = int'($urandom_range(1, 3));
          end
        end else if (CalcOutputReady) begin
          hold--;
          if (hold == 0) CalcOutputReady = 0;
        end
        CalcInputReady = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    ResultReady = 0;
    forever begin
      @(posedge CLK); #1;
      case (readyMode)
        0: ResultReady = 0;
        1: ResultReady = 1;
        default: ResultReady = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: result stream, stall stability, ray summaries.
  initial begin
    logic prevStall;
    logic [42:0] prevFields, fields;
    exp_res_t r;
    exp_sum_t s;
    prevStall = 0; prevFields = '0;
    forever begin
      @(negedge CLK);
      if (!aresetn) begin
        prevStall = 0;
        continue;
      end
      fields = {ResultValid, 8'(ResultIndex), ResultIntersects, ResultDiscriminant, ResultB, ResultLast};
      if (prevStall) check("result_hold", 64'(fields), 64'(prevFields));
      if (ResultValid) check("no_issue_in_emit", 64'(CalcInputValid), 0);
      if (ResultValid && ResultReady) begin
        if (expRes.size() == 0) check("unexpected_result", 1, 0);
        else begin
          r = expRes.pop_front();
          check("result", 64'({8'(ResultIndex), ResultIntersects, ResultDiscriminant,
                               ResultB, ResultLast}), 64'(r));
        end
      end
      prevStall  = ResultValid && !ResultReady;
      prevFields = fields;
      if (RayDone) begin
        doneCount++;
        check("results_drained", 64'(expRes.size()), 0);
        if (expSum.size() == 0) check("unexpected_ray_done", 1, 0);
        else begin
          s = expSum.pop_front();
          check("hit_mask", 64'(HitMask), 64'(s.mask));
          check("hit_count", 64'(HitCount), 64'(s.count));
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic writeSphere(input int addr, input logic [63:0] data, input bit lands);
    SphereWrite = 1; SphereWrAddr = IdxW'(addr); SphereWrData = data;
    tick();
    SphereWrite = 0;
    if (lands) shadow[addr] = data;
  endtask

  task automatic sendRay(input int count, input logic [47:0] st, input logic [47:0] dr);
    int n, hits, waited;
    logic [7:0] mask;
    logic [32:0] m;
    n = (count > NumSpheres) ? NumSpheres : count;
    mask = '0; hits = 0;
    for (int i = 0; i < n; i++) begin
      m = calcModel(shadow[i], st, dr);
      expIssue.push_back('{shadow[i], st, dr});
      expRes.push_back('{8'(i), m[32], m[31:16], m[15:0], (i == n - 1)});
      if (m[32]) begin
        mask[i] = 1'b1;
        hits++;
      end
    end
    expSum.push_back('{mask, 8'(hits)});
    waited = 0;
    while (!RayReady && waited < 200) begin
      tick();
      waited++;
    end
    check("ray_ready_wait", 64'(RayReady), 1);
    SphereCount = CntW'(count); RayStart = st; RayDir = dr; RayValid = 1;
    tick();
    RayValid = 0;
    raysSent++;
  endtask

  task automatic waitRayDone();
    int waited;
    waited = 0;
    while (doneCount < raysSent && waited < 2000) begin
      tick();
      waited++;
    end
    check("ray_completes", 64'(doneCount >= raysSent), 1);
  endtask

  initial begin
    int base, waited;
    SphereWrite = 0; SphereWrAddr = '0; SphereWrData = '0;
    SphereCount = '0; RayValid = 0; RayStart = '0; RayDir = '0;
    for (int i = 0; i < NumSpheres; i++) shadow[i] = '0;

    #1;
    check("reset_ray_ready", 64'(RayReady), 0);
    check("reset_outputs", 64'({ResultValid, CalcInputValid, RayDone, HitMask, HitCount}), 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK); aresetn = 1;
    #1 check("ready_before_first_edge", 64'(RayReady), 0);
    tick();
    check("ready_after_reset", 64'(RayReady), 1);

    // Single sphere straight ahead.
    writeSphere(0, {16'sd0, 16'sd0, 16'sd0, 16'sd2}, 1);
    sendRay(1, {16'sd0, 16'sd0, -16'sd10}, {16'sd0, 16'sd0, 16'sd1});
    expRes[0] = '{8'd0, 1'b1, 16'h0010, 16'hffec, 1'b1};
    expSum[0] = '{8'b1, 8'd1};
    waitRayDone();

    // Two spheres, only the second one is hit.
    writeSphere(0, {16'sd10, -16'sd10, 16'sd10, 16'sd2}, 1);
    writeSphere(1, {16'sd10, 16'sd10, 16'sd0, 16'sd3}, 1);
    sendRay(2, 48'd0, {16'sd1, 16'sd1, 16'sd0});
    expRes[1] = '{8'd1, 1'b1, 16'h0048, 16'hffd8, 1'b1};
    expSum[0] = '{8'b10, 8'd1};
    waitRayDone();

    // Long backpressure on the result stream.
    readyMode = 0;
    sendRay(1, randVec(), randVec());
    waited = 0;
    while (!ResultValid && waited < 100) begin
      tick();
      waited++;
    end
    check("stall_reached_emit", 64'(ResultValid), 1);
    repeat (20) tick();
    check("stall_still_valid", 64'(ResultValid), 1);
    readyMode = 2;
    waitRayDone();

    // Zero-sphere ray and an over-sized count.
    sendRay(0, randVec(), randVec());
    check("n0_ray_done", 64'(RayDone), 1);
    waitRayDone();
    for (int i = 0; i < NumSpheres; i++) writeSphere(i, randSphere(), 1);
    sendRay(NumSpheres + 3, randVec(), randVec());
    waitRayDone();

    // Writes while busy are dropped; the same write in IDLE lands.
    sendRay(2, randVec(), randVec());
    writeSphere(0, 64'h0005_0006_0007_0008, 0);
    writeSphere(0, 64'h0005_0006_0007_0008, 0);
    waitRayDone();
    sendRay(1, randVec(), randVec());
    waitRayDone();
    writeSphere(0, 64'h0005_0006_0007_0008, 1);
    sendRay(1, {16'sd5, 16'sd6, -16'sd3}, {16'sd0, 16'sd0, 16'sd1});
    waitRayDone();

    // Randomized rays with interleaved table updates.
    for (int r = 0; r < 25; r++) begin
      int nw;
      nw = int'($urandom_range(0, 3));
      for (int w = 0; w < nw; w++) writeSphere(int'($urandom_range(0, NumSpheres - 1)), randSphere(), 1);
      readyMode = ($urandom_range(0, 3) == 0) ? 1 : 2;
      sendRay(int'($urandom_range(0, (1 << CntW) - 1)), randVec(), randVec());
      waitRayDone();
    end
    readyMode = 2;

    // Reset while waiting on the calculator.
    for (int i = 0; i < 3; i++) writeSphere(i, randSphere(), 1);
    base = issuedCount;
    sendRay(3, randVec(), randVec());
    waited = 0;
    while (issuedCount == base && waited < 100) begin
      @(posedge CLK); #2;
      waited++;
    end
    check("reached_wait", 64'(issuedCount > base), 1);
    aresetn = 0;
    #1;
    check("midray_reset_ready", 64'(RayReady), 0);
    check("midray_reset_zero", 64'(|{ResultValid, CalcInputValid, RayDone, HitMask, HitCount,
                                      ResultIndex, ResultIntersects, ResultDiscriminant, ResultB,
                                      ResultLast, CalcSphereX, CalcSphereY, CalcSphereZ,
                                      CalcSphereRadius, CalcRayStartX, CalcRayStartY, CalcRayStartZ,
                                      CalcRayDirX, CalcRayDirY, CalcRayDirZ}), 0);
    expRes.delete(); expIssue.delete(); expSum.delete();
    for (int i = 0; i < NumSpheres; i++) shadow[i] = '0;
    raysSent = doneCount;
    repeat (2) @(posedge CLK);
    @(negedge CLK); aresetn = 1;
    tick();
    check("ready_after_midray_reset", 64'(RayReady), 1);
    writeSphere(0, {16'sd0, 16'sd0, 16'sd0, 16'sd4}, 1);
    sendRay(2, {16'sd0, 16'sd0, -16'sd9}, {16'sd0, 16'sd0, 16'sd1});
    waitRayDone();

    repeat (5) tick();
    check("final_drain", 64'(expRes.size() + expIssue.size() + expSum.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
